combo_sequencer: RTL and testbench
==================================

COMBO_SEQUENCER -- requirements
Module: combo_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: maximum number of stored code steps.
REQ-002 Parameter HOLD_W, default 16: width of the per-step hold counter.
REQ-003 Port clock, input, 1 bit: the single clock; every flop is posedge clock.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port load_en, input, 1 bit: appends load_data to the code list on this cycle.
REQ-006 Port load_data, input, 3 bits: switch code to store.
REQ-007 Port clear, input, 1 bit: empties the code list.
REQ-008 Port start, input, 1 bit: begins playback of the stored list.
REQ-009 Port hold_cycles, input, HOLD_W bits: cycles each code is held on x_out, sampled at start.
REQ-010 Port x_out, output, 3 bits: code presented to the lock's switch input.
REQ-011 Port busy, output, 1 bit: high while playback is in progress.
REQ-012 Port done, output, 1 bit: one-cycle pulse when playback completes.
REQ-013 Port err, output, 1 bit: one-cycle pulse on a rejected load or rejected start.
REQ-014 Port count, output, clog2(DEPTH)+1 bits: number of stored steps.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRIVE, FINISH.
REQ-016 In IDLE, load_en with count<DEPTH SHALL write load_data at index count and increment count on the next edge.
REQ-017 load_en with count==DEPTH, or load_en while busy, SHALL leave storage unchanged and pulse err the next cycle.
REQ-018 clear in IDLE SHALL set count to 0 the next cycle; clear while busy SHALL be ignored with no err.
REQ-019 If clear and load_en are asserted in the same IDLE cycle, clear SHALL win and the load SHALL be dropped silently.
REQ-020 start in IDLE with count>0 SHALL latch hold_cycles, treating 0 as 1, set rd_ptr=0, and enter DRIVE on the next edge.
REQ-021 If load_en is asserted in the same cycle as such a start, the load SHALL be accepted first, and playback SHALL include the new step.
REQ-022 start in IDLE with count==0 SHALL stay in IDLE and pulse err.
REQ-023 start while busy SHALL be ignored with no err.
REQ-024 In DRIVE, x_out SHALL equal code[rd_ptr], registered, and be held exactly the latched number of hold cycles per step.
REQ-025 When a step's hold expires and rd_ptr<count-1, the FSM SHALL increment rd_ptr and reload the hold counter, with no gap cycle between steps.
REQ-026 When the last step's hold expires, the FSM SHALL enter FINISH.
REQ-027 FINISH SHALL last one cycle: x_out=3'b000, done=1, busy=0, then return to IDLE.
REQ-028 In IDLE, x_out SHALL be 3'b000.
REQ-029 busy SHALL be 1 exactly during DRIVE.
REQ-030 Storage and count SHALL be preserved across playback, so a list can be replayed.
REQ-031 First-step latency SHALL be fixed: x_out shows code[0] in the first cycle after the start edge.

Reset
REQ-032 Asserting rst_n low, at any time including mid-playback, SHALL force IDLE, count=0, rd_ptr=0, hold counter=0, x_out=3'b000, busy=0, done=0, err=0.
REQ-033 Code storage SHALL NOT be reset; it is unreadable once count is 0.

Structure
REQ-034 A shared package SHALL hold the state enumeration (IDLE, DRIVE, FINISH) and the constant CODE_W=3.
REQ-035 One sub-module, combo_hold_timer, SHALL implement the loadable HOLD_W down-counter and its expire pulse; the rest stays in combo_sequencer.

Verification
REQ-036 Scenario 1: load 010,110,111,011,001 then start with hold_cycles=4 -> x_out shows each code for 4 cycles in order, then done pulses once, then x_out=000.
REQ-037 Scenario 2: load DEPTH+1 codes -> count=8, and err pulses only on the 9th load.
REQ-038 Scenario 3: start with count=0 -> err pulse, busy stays 0, x_out=000.
REQ-039 Scenario 4: rst_n low during step 3 of playback -> x_out=000, busy=0, count=0 asynchronously, with no done pulse.
REQ-040 Scenario 5: hold_cycles=0 with 2 codes -> each code is held 1 cycle, and done comes 3 cycles after the start edge.
REQ-041 Scenario 6: clear, load_en and start asserted together in IDLE with count=2 -> count becomes 0, playback of the 2 old codes, err stays 0.

Source files
------------

// File: rtl/combo_sequencer_pkg.sv
// Shared types and constants for the combination-lock code sequencer.
package combo_sequencer_pkg;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        FINISH
    } state_t;
endpackage

// File: rtl/combo_hold_timer.sv
// Loadable down-counter; expire_o flags the last cycle of a hold while enabled.
module combo_hold_timer #(
    parameter int HOLD_W = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [HOLD_W-1:0] load_val_i,
    input  logic              en_i,
    output logic              expire_o
);
    logic [HOLD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - HOLD_W'(1);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/combo_sequencer.sv
// Stores up to DEPTH switch codes and replays them on x_out, each held for a
// programmable number of cycles.
module combo_sequencer
    import combo_sequencer_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int HOLD_W = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [CODE_W-1:0] load_data,
    input  logic              clear,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [CODE_W-1:0] x_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  count
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [HOLD_W-1:0] hold_m1_q, hold_m1_d;
    logic [CODE_W-1:0] x_out_q, x_out_d;
    logic              err_q, err_d;
    logic [CODE_W-1:0] mem_q [DEPTH];
    logic              mem_we, load_ok, last_step;
    logic              tmr_load, tmr_expire;
    logic [HOLD_W-1:0] tmr_val;

    assign load_ok   = load_en && !clear && (count_q < CNT_W'(DEPTH));
    assign last_step = (CNT_W'(rd_ptr_q) + CNT_W'(1)) == len_q;

    // Playback length is latched at start so a simultaneous clear does not
    // cut short the list being replayed.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        rd_ptr_d  = rd_ptr_q;
        hold_m1_d = hold_m1_q;
        x_out_d   = '0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = hold_m1_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (load_en) begin
                    if (load_ok) begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (start) begin
                    if (count_q != '0) begin
                        state_d   = DRIVE;
                        rd_ptr_d  = '0;
                        len_d     = load_ok ? count_q + CNT_W'(1) : count_q;
                        hold_m1_d = (hold_cycles == '0) ? '0 : hold_cycles - HOLD_W'(1);
                        tmr_load  = 1'b1;
                        tmr_val   = hold_m1_d;
                        x_out_d   = mem_q[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                err_d   = load_en;
                x_out_d = x_out_q;
                if (tmr_expire) begin
                    if (last_step) begin
                        state_d = FINISH;
                        x_out_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        tmr_load = 1'b1;
                        x_out_d  = mem_q[rd_ptr_d];
                    end
                end
            end
            FINISH: begin
                err_d   = load_en;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            len_q     <= '0;
            rd_ptr_q  <= '0;
            hold_m1_q <= '0;
            x_out_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            rd_ptr_q  <= rd_ptr_d;
            hold_m1_q <= hold_m1_d;
            x_out_q   <= x_out_d;
            err_q     <= err_d;
        end
    end

    // Code storage is deliberately left unreset; count gates its visibility.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[PTR_W'(count_q)] <= load_data;
    end

    combo_hold_timer #(.HOLD_W(HOLD_W)) u_timer (
        .clock      (clock),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (state_q == DRIVE),
        .expire_o   (tmr_expire)
    );

    assign x_out = x_out_q;
    assign busy  = (state_q == DRIVE);
    assign done  = (state_q == FINISH);
    assign err   = err_q;
    assign count = count_q;
endmodule

// File: tb/tb_combo_sequencer.sv
// Scoreboard bench: stimulus queues expected {busy,done,err,x_out} per active cycle.
module tb_combo_sequencer;
    localparam int DEPTH  = 8;
    localparam int HOLD_W = 16;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_en = 1'b0, clear = 1'b0, start = 1'b0;
    logic [2:0]        load_data = '0;
    logic [HOLD_W-1:0] hold_cycles = '0;
    logic [2:0]        x_out;
    logic              busy, done, err;
    logic [$clog2(DEPTH):0] count;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] exp_q[$];
    logic [2:0] s1_codes [5] = '{3'b010, 3'b110, 3'b111, 3'b011, 3'b001};

    always #5 clock = ~clock;

    combo_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clock(clock), .rst_n(rst_n), .load_en(load_en), .load_data(load_data),
        .clear(clear), .start(start), .hold_cycles(hold_cycles),
        .x_out(x_out), .busy(busy), .done(done), .err(err), .count(count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic b, input logic d, input logic e, input logic [2:0] x);
        exp_q.push_back({b, d, e, x});
    endtask

    task automatic step(input logic le, input logic [2:0] ld, input logic clr,
                        input logic st, input logic [HOLD_W-1:0] hc);
        load_en = le; load_data = ld; clear = clr; start = st; hold_cycles = hc;
        @(posedge clock); #1;
        load_en = 1'b0; load_data = '0; clear = 1'b0; start = 1'b0; hold_cycles = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 3'b000, 1'b0, 1'b0, '0);
    endtask

    // Monitor: every cycle the DUT shows busy/done/err is scored against the queue.
    always @(negedge clock) begin
        if (rst_n === 1'b1 && (busy || done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", {busy, done, err, x_out});
            end else begin
                check("out_seq", {26'd0, busy, done, err, x_out}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1;
        check("rst_x_out", x_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_count", count, 0);
        @(negedge clock); rst_n = 1'b1;
        @(posedge clock); #1;

        // Scenario 1: five codes, hold 4
        for (int i = 0; i < 5; i++) step(1'b1, s1_codes[i], 1'b0, 1'b0, '0);
        check("s1_count", count, 5);
        for (int i = 0; i < 5; i++) repeat (4) push(1'b1, 1'b0, 1'b0, s1_codes[i]);
        push(1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b0, 3'b000, 1'b0, 1'b1, 16'd4);
        idle(22);
        check("s1_idle_x", x_out, 0);
        check("s1_idle_busy", busy, 0);
        check("s1_count_kept", count, 5);

        // Scenario 2: overflow the list, then replay to show storage untouched
        step(1'b0, 3'b000, 1'b1, 1'b0, '0);
        check("s2_cleared", count, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 1'b0, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, 3'b000);
        step(1'b1, 3'b101, 1'b0, 1'b0, '0);
        check("s2_count_full", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) push(1'b1, 1'b0, 1'b0, 3'(i));
        push(1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b0, 3'b000, 1'b0, 1'b1, 16'd1);
        idle(10);

        // Scenario 3: start on an empty list
        step(1'b0, 3'b000, 1'b1, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, 3'b000);
        step(1'b0, 3'b000, 1'b0, 1'b1, 16'd3);
        check("s3_busy", busy, 0);
        check("s3_x_out", x_out, 0);
        idle(3);
        check("s3_busy_later", busy, 0);

        // Scenario 5: hold 0 behaves as 1, fixed first-step latency
        step(1'b1, 3'b100, 1'b0, 1'b0, '0);
        step(1'b1, 3'b011, 1'b0, 1'b0, '0);
        push(1'b1, 1'b0, 1'b0, 3'b100);
        push(1'b1, 1'b0, 1'b0, 3'b011);
        push(1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b0, 3'b000, 1'b0, 1'b1, 16'd0);
        check("s5_first_step", {busy, x_out}, {1'b1, 3'b100});
        idle(1);
        check("s5_second_step", {busy, x_out}, {1'b1, 3'b011});
        idle(1);
        check("s5_done_cycle3", {done, busy, x_out}, 5'b10000);
        idle(2);

        // Scenario 6: clear + load + start together with count 2
        check("s6_count_before", count, 2);
        push(1'b1, 1'b0, 1'b0, 3'b100);
        push(1'b1, 1'b0, 1'b0, 3'b011);
        push(1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b1, 3'b111, 1'b1, 1'b1, 16'd1);
        check("s6_count_zero", count, 0);
        idle(4);
        check("s6_count_after", count, 0);

        // Load accepted alongside start; load and start while busy
        step(1'b1, 3'b010, 1'b0, 1'b0, '0);
        push(1'b1, 1'b0, 1'b0, 3'b010);
        push(1'b1, 1'b0, 1'b1, 3'b010);
        push(1'b1, 1'b0, 1'b0, 3'b110);
        push(1'b1, 1'b0, 1'b0, 3'b110);
        push(1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b1, 3'b110, 1'b0, 1'b1, 16'd2);
        step(1'b1, 3'b101, 1'b0, 1'b0, '0);
        step(1'b0, 3'b000, 1'b0, 1'b1, 16'd5);
        idle(4);
        check("busy_rejects_count", count, 2);

        // Scenario 4: asynchronous reset during step 3
        step(1'b0, 3'b000, 1'b1, 1'b0, '0);
        step(1'b1, 3'b001, 1'b0, 1'b0, '0);
        step(1'b1, 3'b010, 1'b0, 1'b0, '0);
        step(1'b1, 3'b100, 1'b0, 1'b0, '0);
        repeat (3) push(1'b1, 1'b0, 1'b0, 3'b001);
        repeat (3) push(1'b1, 1'b0, 1'b0, 3'b010);
        step(1'b0, 3'b000, 1'b0, 1'b1, 16'd3);
        idle(6);
        check("s4_step3_shown", {busy, x_out}, {1'b1, 3'b100});
        #2 rst_n = 1'b0;
        #1;
        check("s4_async_x", x_out, 0);
        check("s4_async_busy", busy, 0);
        check("s4_async_count", count, 0);
        check("s4_async_done_err", {done, err}, 0);
        @(posedge clock); #3 rst_n = 1'b1;
        @(posedge clock); #1;
        idle(5);
        check("s4_no_done", {done, busy}, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
